// File: rtl/act_sram_if.sv
// act_sram_if: conv-engine to activation-bank bus.
// master drives sram_raddr, sram_wen (active-low), sram_wordmask (1 = keep lane), sram_waddr, sram_wdata;
// slave returns the registered sram_rdata.
interface act_sram_if #(
   parameter int ADDR_BW = 14,
   parameter int L       = 36,
   parameter int W       = 360
);
   logic [ADDR_BW-1:0] sram_raddr;
   logic [W-1:0]       sram_rdata;
   logic               sram_wen;
   logic [L-1:0]       sram_wordmask;
   logic [ADDR_BW-1:0] sram_waddr;
   logic [W-1:0]       sram_wdata;
   modport master (output sram_raddr, sram_wen, sram_wordmask, sram_waddr, sram_wdata, input sram_rdata);
   modport slave  (input sram_raddr, sram_wen, sram_wordmask, sram_waddr, sram_wdata, output sram_rdata);
endinterface

// File: rtl/act_sram_bank.sv
// act_sram_bank: self-clearing activation SRAM bank with per-lane masked writes and write-first reads.
// Ports: clk, rst (sync active-high); init_busy (clear sweep running); oob_err (sticky out-of-range access);
// bus (act_sram_if.slave): read/write address, data, active-low write enable, per-lane keep mask.
module act_sram_bank #(
   parameter int CH_NUM       = 4,
   parameter int ACT_PER_ADDR = 9,
   parameter int BW_PER_ACT   = 10,
   parameter int ADDR_BW      = 14,
   parameter int DEPTH        = 1024
) (
   input  logic      clk,
   input  logic      rst,
   output logic      init_busy,
   output logic      oob_err,
   act_sram_if.slave bus
);
   localparam int L  = CH_NUM * ACT_PER_ADDR;
   localparam int W  = L * BW_PER_ACT;
   localparam int AW = $clog2(DEPTH);
   // one extra bit so DEPTH == 2**ADDR_BW still compares correctly
   localparam logic [ADDR_BW:0] DEPTH_W = (ADDR_BW + 1)'(DEPTH);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   typedef enum logic {CLEAR, READY} state_t;
   state_t         state, state_d;
   logic [AW-1:0]  clr_ptr, clr_d;
   logic [W-1:0]   mem [DEPTH];
   logic [W-1:0]   wbits, rd_word, rd_fwd, rdata_d;
   logic           r_in, w_in, wr_ok, hit, oob_d;
   // expand the lane keep-mask into a per-bit write mask (1 = take wdata)
   for (genvar k = 0; k < L; k++) begin : g_lane
      assign wbits[k*BW_PER_ACT +: BW_PER_ACT] = {BW_PER_ACT{~bus.sram_wordmask[k]}};
   end
   assign r_in      = {1'b0, bus.sram_raddr} < DEPTH_W;
   assign w_in      = {1'b0, bus.sram_waddr} < DEPTH_W;
   assign wr_ok     = state == READY && !rst && !bus.sram_wen && w_in;
   assign rd_word   = mem[bus.sram_raddr[AW-1:0]];
   assign init_busy = state == CLEAR;
   always_comb begin
      state_d = (state == CLEAR && clr_ptr == LAST) ? READY : state;
      clr_d   = (state == CLEAR) ? clr_ptr + 1'b1 : '0;
      hit     = wr_ok && bus.sram_waddr == bus.sram_raddr;
      rd_fwd  = hit ? (rd_word & ~wbits) | (bus.sram_wdata & wbits) : rd_word;
      rdata_d = (state == READY && r_in) ? rd_fwd : '0;
      oob_d   = oob_err | (state == READY && (!r_in || (!bus.sram_wen && !w_in)));
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= CLEAR;
         clr_ptr        <= '0;
         bus.sram_rdata <= '0;
         oob_err        <= 1'b0;
      end else begin
         state          <= state_d;
         clr_ptr        <= clr_d;
         bus.sram_rdata <= rdata_d;
         oob_err        <= oob_d;
      end
   end
   // storage: clear sweep has priority; user writes only land once READY
   always_ff @(posedge clk) begin
      if (state == CLEAR && !rst) mem[clr_ptr] <= '0;
      else if (wr_ok) mem[bus.sram_waddr[AW-1:0]] <= (mem[bus.sram_waddr[AW-1:0]] & ~wbits) | (bus.sram_wdata & wbits);
   end
endmodule

// File: tb/tb_act_sram_bank.sv
// tb_act_sram_bank: scoreboard bench for act_sram_bank at DEPTH=16.
module tb_act_sram_bank;
   localparam int L  = 36;
   localparam int B  = 10;
   localparam int W  = L * B;
   localparam int D  = 16;
   localparam int AB = 14;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic init_busy, oob_err;
   int checks = 0;
   int errors = 0;
   logic [W-1:0] model [D];
   logic [W-1:0] exp_q [$];
   logic exp_oob = 1'b0;
   act_sram_if #(.ADDR_BW(AB), .L(L), .W(W)) bus();
   act_sram_bank #(.DEPTH(D)) dut (.clk(clk), .rst(rst), .init_busy(init_busy), .oob_err(oob_err), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic logic [W-1:0] lane_bits(input logic [L-1:0] m);
      logic [W-1:0] r;
      for (int k = 0; k < L; k++) r[k*B +: B] = m[k] ? '0 : '1;
      return r;
   endfunction
   task automatic step(input logic [AB-1:0] ra, input logic we_n, input logic [L-1:0] m,
                       input logic [AB-1:0] wa, input logic [W-1:0] wd, input string tag);
      logic [W-1:0] wb, e;
      logic wv;
      @(negedge clk);
      bus.sram_raddr = ra;
      bus.sram_wen = we_n;
      bus.sram_wordmask = m;
      bus.sram_waddr = wa;
      bus.sram_wdata = wd;
      wb = lane_bits(m);
      wv = !we_n && int'(wa) < D;
      e = (int'(ra) < D) ? model[ra[3:0]] : '0;
      if (wv && wa == ra) e = (e & ~wb) | (wd & wb);
      if (wv) model[wa[3:0]] = (model[wa[3:0]] & ~wb) | (wd & wb);
      if (int'(ra) >= D || (!we_n && int'(wa) >= D)) exp_oob = 1'b1;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check(tag, bus.sram_rdata, exp_q.pop_front());
      check({tag, "_oob"}, W'(oob_err), W'(exp_oob));
      bus.sram_wen = 1'b1;
   endtask
   task automatic rd(input logic [AB-1:0] ra, input string tag);
      step(ra, 1'b1, '1, '0, '0, tag);
   endtask
   task automatic rst_pulse(input string tag);
      @(negedge clk);
      rst = 1'b1;
      bus.sram_wen = 1'b1;
      @(posedge clk);
      #1;
      check({tag, "_busy"}, W'(init_busy), W'(1));
      check({tag, "_rdata"}, bus.sram_rdata, '0);
      check({tag, "_oob"}, W'(oob_err), W'(0));
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < D; i++) model[i] = '0;
      exp_oob = 1'b0;
   endtask
   // counts busy cycles while hammering writes that must be ignored
   task automatic wait_clear(input string tag);
      int cnt;
      cnt = 0;
      do begin
         if (cnt > 0) @(negedge clk);
         bus.sram_wen = 1'b0;
         bus.sram_waddr = 14'd2;
         bus.sram_wordmask = '0;
         bus.sram_wdata = '1;
         bus.sram_raddr = 14'd2;
         @(posedge clk);
         #1;
         cnt++;
         check({tag, "_clr_rdata"}, bus.sram_rdata, '0);
      end while (init_busy && cnt < 100);
      bus.sram_wen = 1'b1;
      check(tag, W'(cnt), W'(D));
   endtask
   initial begin
      logic [W-1:0] wd;
      bus.sram_raddr = '0;
      bus.sram_wen = 1'b1;
      bus.sram_wordmask = '1;
      bus.sram_waddr = '0;
      bus.sram_wdata = '0;
      repeat (2) @(posedge clk);
      rst_pulse("rst1");
      wait_clear("busy_len");
      rd(14'd5, "rd5_zero");
      rd(14'd2, "clear_write_ignored");
      for (int k = 0; k < L; k++) wd[k*B +: B] = B'(k);
      step(14'd0, 1'b0, '0, 14'd3, wd, "wr3_full");
      rd(14'd3, "rd3_lanes");
      wd = '0;
      wd[B-1:0] = 10'h155;
      step(14'd0, 1'b0, ~36'h1, 14'd3, wd, "wr3_lane0");
      rd(14'd3, "rd3_masked");
      step(14'd7, 1'b0, ~36'h3, 14'd7, '1, "same_cycle");
      rd(14'd7, "rd7_after");
      step(14'd3, 1'b0, '1, 14'd3, '1, "mask_all_ones");
      for (int i = 0; i < 20; i++) begin
         wd = {12{$urandom()}};
         step(AB'($urandom_range(0, D-1)), 1'($urandom_range(0, 1)), {$urandom(), 4'($urandom())},
              AB'($urandom_range(0, D-1)), wd, "rand");
      end
      step(14'd20, 1'b0, '0, 14'd16, '1, "oob_rw");
      rd(14'd0, "no_alias0");
      rd(14'd4, "no_alias4");
      rd(14'd3, "oob_sticky");
      rst_pulse("rst2");
      repeat (8) @(posedge clk);
      rst_pulse("rst_mid");
      wait_clear("busy_restart");
      for (int a = 0; a < D; a++) rd(AB'(a), "post_clear");
      step(14'd1, 1'b0, '0, 14'd17, '1, "oob_wr_only");
      rst_pulse("rst3");
      wait_clear("busy_len3");
      step(14'd16, 1'b1, '1, 14'd0, '0, "oob_rd_only");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
